// File: rtl/uart_rx_frame_counter.sv
// UART Rx oversampling edge/bit counter with sample, bit and frame strobes.
// Define UART_RX_CNT_TRIPLE_SAMPLE_EN for three sample points per bit.
module uart_rx_frame_counter #(
    parameter int PRESCALE_WIDTH = 6,
    parameter int BIT_CNT_WIDTH  = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      Count_En,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic [3:0]                Data_Len,
    input  logic                      Par_En,
    input  logic                      Stop2,
    output logic [PRESCALE_WIDTH-1:0] Edge_Cnt,
    output logic [BIT_CNT_WIDTH-1:0]  Bit_Cnt,
    output logic                      Sample_Strobe,
    output logic [1:0]                Sample_Idx,
    output logic                      Bit_Done,
    output logic                      Frame_Done,
    output logic                      Cfg_Err
);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t                    state;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic [BIT_CNT_WIDTH-1:0]  last_bit_q;
    logic [BIT_CNT_WIDTH-1:0]  last_bit;
    logic [PRESCALE_WIDTH-1:0] mid;
    logic                      cfg_ok;
    logic                      active;

    // Index of the final stop bit: L-1 = 1 + Data_Len + Par_En + Stop2
    assign last_bit = BIT_CNT_WIDTH'(Data_Len) + BIT_CNT_WIDTH'(1)
                    + BIT_CNT_WIDTH'(Par_En) + BIT_CNT_WIDTH'(Stop2);

    assign cfg_ok = (Prescale >= PRESCALE_WIDTH'(4))
                 && (Data_Len >= 4'd5) && (Data_Len <= 4'd8);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            Edge_Cnt   <= '0;
            Bit_Cnt    <= '0;
            Cfg_Err    <= 1'b0;
            prescale_q <= '0;
            last_bit_q <= '0;
        end else if (!Count_En) begin
            state    <= IDLE;
            Edge_Cnt <= '0;
            Bit_Cnt  <= '0;
            Cfg_Err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A rejected config stays rejected until Count_En drops
                    if (!Cfg_Err) begin
                        prescale_q <= Prescale;
                        last_bit_q <= last_bit;
                        if (cfg_ok) begin
                            state    <= COUNT;
                            Edge_Cnt <= PRESCALE_WIDTH'(1);
                            Bit_Cnt  <= '0;
                        end else begin
                            Cfg_Err <= 1'b1;
                        end
                    end
                end
                COUNT: begin
                    if (Edge_Cnt == prescale_q) begin
                        Edge_Cnt <= PRESCALE_WIDTH'(1);
                        if (Bit_Cnt == last_bit_q)
                            Bit_Cnt <= '0;
                        else
                            Bit_Cnt <= Bit_Cnt + BIT_CNT_WIDTH'(1);
                    end else begin
                        Edge_Cnt <= Edge_Cnt + PRESCALE_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign active     = (state == COUNT) && Count_En;
    assign mid        = prescale_q >> 1;
    assign Bit_Done   = active && (Edge_Cnt == prescale_q);
    assign Frame_Done = Bit_Done && (Bit_Cnt == last_bit_q);

`ifdef UART_RX_CNT_TRIPLE_SAMPLE_EN
    always_comb begin
        Sample_Strobe = 1'b0;
        Sample_Idx    = 2'd0;
        if (active) begin
            unique case (1'b1)
                (Edge_Cnt == mid - PRESCALE_WIDTH'(1)): begin
                    Sample_Strobe = 1'b1;
                    Sample_Idx    = 2'd0;
                end
                (Edge_Cnt == mid): begin
                    Sample_Strobe = 1'b1;
                    Sample_Idx    = 2'd1;
                end
                (Edge_Cnt == mid + PRESCALE_WIDTH'(1)): begin
                    Sample_Strobe = 1'b1;
                    Sample_Idx    = 2'd2;
                end
                default: ;
            endcase
        end
    end
`else
    assign Sample_Strobe = active && (Edge_Cnt == mid);
    assign Sample_Idx    = 2'd0;
`endif

endmodule

// File: doc/uart_rx_frame_counter.md
Name: uart_rx_frame_counter

Overview:
Parametrised oversampling counter for the UART receiver. It tracks the edge count within each bit and the bit index within a frame. It also decodes sample-point, bit-done and frame-done strobes for the Rx FSM and sampler. Frame length is runtime-configurable: data bits, parity and stop bits.

Parameters:
PRESCALE_WIDTH, 6, width of Prescale and Edge_Cnt; supports oversampling ratios up to 2^PRESCALE_WIDTH-1.
BIT_CNT_WIDTH, 4, width of Bit_Cnt; must hold the maximum frame length of 12.

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  asynchronous active-low reset.
Count_En  input  1  count enable from Rx FSM; high for the whole frame(s).
Prescale  input  PRESCALE_WIDTH  oversampling ratio; valid range 4..2^PRESCALE_WIDTH-1.
Data_Len  input  4  data bits per frame; valid range 5..8.
Par_En  input  1  parity bit present.
Stop2  input  1  0 = one stop bit, 1 = two stop bits.
Edge_Cnt  output  PRESCALE_WIDTH  edge index within current bit (1..Prescale while counting).
Bit_Cnt  output  BIT_CNT_WIDTH  bit index within frame; start bit = 0.
Sample_Strobe  output  1  sample point(s) of the current bit.
Sample_Idx  output  2  which of the three samples is being taken (0,1,2).
Bit_Done  output  1  last edge of current bit.
Frame_Done  output  1  last edge of last stop bit.
Cfg_Err  output  1  latched configuration was invalid.

Behaviour:
- Reset: Edge_Cnt=0, Bit_Cnt=0, Cfg_Err=0, latched config cleared, state IDLE; all strobes low.
- Two-state FSM, IDLE/COUNT.
- IDLE with Count_En=1: latch the configuration on this edge.
  - Latched values: Prescale_q, Data_Len, Par_En, Stop2, and L = 2 + Data_Len + Par_En + Stop2 (range 7..12).
  - Config invalid (Prescale<4 or Data_Len outside 5..8): Cfg_Err<=1, counters stay 0, remain IDLE until Count_En=0.
  - Config valid: go to COUNT, Edge_Cnt<=1, Bit_Cnt<=0.
- Mid-frame config changes are ignored; only latched values are used.
- COUNT, Count_En=1, Edge_Cnt<Prescale_q: Edge_Cnt increments.
- COUNT, Count_En=1, Edge_Cnt==Prescale_q: Edge_Cnt<=1.
  - Bit_Cnt<L-1: Bit_Cnt increments.
  - Bit_Cnt==L-1: Bit_Cnt<=0 (wrap); the next frame starts back-to-back with the same latched config.
- Count_En=0 in any state:
  - Next edge: Edge_Cnt=0, Bit_Cnt=0, state IDLE, Cfg_Err cleared.
  - An aborted frame produces no Frame_Done.
- Strobes are combinational decodes of registered state, gated by state==COUNT and Count_En=1:
  - Bit_Done = (Edge_Cnt==Prescale_q).
  - Frame_Done = Bit_Done and (Bit_Cnt==L-1).
  - Sample point centre M = floor(Prescale_q/2).
- Frame_Done and Bit_Done coincide on the last edge of the frame.
- Arithmetic: all compares are unsigned at PRESCALE_WIDTH width. Edge_Cnt never exceeds Prescale_q. Bit_Cnt never exceeds L-1.
- Reset asserted mid-frame clears everything asynchronously. The first enabled edge after release restarts from IDLE.

Optional Feature:
Macro UART_RX_CNT_TRIPLE_SAMPLE_EN.
- Defined: Sample_Strobe is high at Edge_Cnt = M-1, M, M+1, with Sample_Idx = 0, 1, 2 respectively. Used for 2-of-3 majority voting.
- Undefined: Sample_Strobe is high only at Edge_Cnt = M; Sample_Idx is tied to 0.

Test Plan:
1. Prescale=8, Data_Len=8, Par_En=0, Stop2=0, Count_En held high for 80 cycles.
   - Expect Bit_Done every 8 cycles and Frame_Done at cycle 80 with Bit_Cnt=9.
   - Then Bit_Cnt=0, Edge_Cnt=1.
2. Prescale=16, Data_Len=7, Par_En=1, Stop2=1, so L=11.
   - Expect Frame_Done at cycle 176.
   - Sample_Strobe at Edge_Cnt 7, 8, 9 (Sample_Idx 0, 1, 2) with the macro defined; only at Edge_Cnt 8 without it.
3. Prescale=8, L=10; drop Count_En at Bit_Cnt=4, Edge_Cnt=5.
   - Next cycle: Edge_Cnt=0, Bit_Cnt=0, no Frame_Done.
   - Re-enable: first edge gives Edge_Cnt=1.
4. Change Prescale 8->16 mid-frame with Count_En high.
   - Current and subsequent back-to-back frames keep the 8-edge bit timing until Count_En is cycled.
5. Enable with Prescale=3, or with Data_Len=9.
   - Expect Cfg_Err=1, counters stuck at 0, no strobes.
   - Count_En=0 clears Cfg_Err.
6. Assert RST at Bit_Cnt=6 mid-frame.
   - All outputs go 0 immediately.
   - After release with Count_En high, counting restarts with Edge_Cnt=1, Bit_Cnt=0.
